// File: rtl/dna_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dna_pkg
// Brief    : Shared types and constants for the DNA pattern scan scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dna_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } sched_state_e;

  localparam logic [7:0] ASC_A = 8'h41;
  localparam logic [7:0] ASC_C = 8'h43;
  localparam logic [7:0] ASC_G = 8'h47;
  localparam logic [7:0] ASC_T = 8'h54;

  localparam int PAT_LEN = 8;
  // "ATATGCGA", first character in the most significant byte
  localparam logic [8*PAT_LEN-1:0] PATTERN =
    {ASC_A, ASC_T, ASC_A, ASC_T, ASC_G, ASC_C, ASC_G, ASC_A};

  function automatic logic [7:0] pat_char(input logic [2:0] idx);
    return PATTERN[8*(PAT_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dna_scan_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dna_scan_sched_if
// Brief    : Requester streams and result bus of the DNA scan scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface dna_scan_sched_if #(
  parameter int NCH     = 4,
  parameter int CNT_MAX = 3
);
  logic [NCH-1:0]                 req_valid;
  logic [8*NCH-1:0]               req_data;
  logic [NCH-1:0]                 req_last;
  logic [NCH-1:0]                 req_ready;
  logic                           res_valid;
  logic [$clog2(NCH)-1:0]         res_chan;
  logic [$clog2(CNT_MAX+1)-1:0]   res_cnt;
  logic                           res_danger;
  logic                           busy;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, res_valid, res_chan, res_cnt, res_danger, busy
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, res_valid, res_chan, res_cnt, res_danger, busy
  );
endinterface
`default_nettype wire

// File: rtl/dna_matcher.sv
`default_nettype none
// ============================================================================
// Module   : dna_matcher
// Brief    : Counts "ATATGCGA" occurrences, saturating at CNT_MAX.
//            DNA_SCAN_OVERLAP_EN: reuse the trailing 'A' after a match.
// Revision : 1.0 - initial release
// ============================================================================
module dna_matcher
  import dna_pkg::*;
#(
  parameter int CNT_MAX = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           step,
  input  logic [7:0]                     ch,
  output logic [$clog2(CNT_MAX+1)-1:0]   cnt,
  output logic                           sat
);
  localparam int CW = $clog2(CNT_MAX+1);

  logic [2:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(CNT_MAX));
  assign cnt = cnt_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (clr) begin
      st_d  = '0;
      cnt_d = '0;
    end else if (step && !sat) begin
      if (ch == pat_char(st_q)) begin
        if (st_q == 3'(PAT_LEN-1)) begin
          cnt_d = cnt_q + 1'b1;
`ifdef DNA_SCAN_OVERLAP_EN
          st_d  = 3'd1;
`else
          st_d  = 3'd0;
`endif
        end else begin
          st_d = st_q + 3'd1;
        end
      end else if (ch == ASC_A) begin
        // "ATATA" keeps the suffix "ATA"; every other 'A' mismatch restarts at "A"
        st_d = (st_q == 3'd4) ? 3'd3 : 3'd1;
      end else begin
        st_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dna_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : dna_scan_sched
// Brief    : Round-robin arbiter feeding whole sequences to one DNA matcher.
// Revision : 1.0 - initial release
// ============================================================================
module dna_scan_sched
  import dna_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  dna_scan_sched_if.slave  bus
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(CNT_MAX+1);

  sched_state_e   state_q, state_d;
  logic [CHW-1:0] grant_q, grant_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic [CHW-1:0] pick, idx;
  logic           any_valid;
  logic           accept, sel_last, clr;
  logic [7:0]     sel_byte;
  logic [CW-1:0]  cnt;
  logic           sat;

  // Descending scan so the candidate closest to rr_q is written last and wins
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    idx       = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = CHW'((int'(rr_q) + k) % NCH);
      if (bus.req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  assign sel_byte = bus.req_data[{grant_q, 3'b000} +: 8];
  assign sel_last = bus.req_last[grant_q];
  assign accept   = (state_q == STREAM) && bus.req_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (any_valid) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && sel_last) state_d = REPORT;
      end
      REPORT: begin
        rr_d    = (grant_q == CHW'(NCH-1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == STREAM) bus.req_ready[grant_q] = 1'b1;
  end

  // Result fields are zeroed outside REPORT so idle outputs read as reset values
  assign bus.res_valid  = (state_q == REPORT);
  assign bus.res_chan   = bus.res_valid ? grant_q : '0;
  assign bus.res_cnt    = bus.res_valid ? cnt : '0;
  assign bus.res_danger = bus.res_valid && sat;
  assign bus.busy       = (state_q != IDLE);

  dna_matcher #(
    .CNT_MAX (CNT_MAX)
  ) u_matcher (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .step  (accept),
    .ch    (sel_byte),
    .cnt   (cnt),
    .sat   (sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_dna_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dna_scan_sched
// Brief    : Directed self-checking bench for dna_scan_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dna_scan_sched;
  localparam int NCH     = 4;
  localparam int CNT_MAX = 3;
`ifdef DNA_SCAN_OVERLAP_EN
  localparam int OVL_CNT = 2;
`else
  localparam int OVL_CNT = 1;
`endif

  typedef struct {
    int chan;
    int cnt;
    int dng;
    int cyc;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dna_scan_sched_if #(.NCH(NCH), .CNT_MAX(CNT_MAX)) bus ();

  dna_scan_sched #(.NCH(NCH), .CNT_MAX(CNT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       v [NCH];
  logic       l [NCH];
  logic [7:0] d [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_drv
    assign bus.req_valid[i]       = v[i];
    assign bus.req_last[i]        = l[i];
    assign bus.req_data[8*i +: 8] = d[i];
  end

  int   cyc = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_tot = 0;
  int   rd_idx = 0;
  res_t rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.res_valid)
      rq.push_back('{int'(bus.res_chan), int'(bus.res_cnt), int'(bus.res_danger), cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams s on channel ch; returns accepted count and first/last accept cycles
  task automatic send(input int ch, input string s, input int gap_at, input int gap_len,
                      input bit use_last, output int n_acc, output int c_first, output int c_last);
    int w;
    n_acc = 0; c_first = -1; c_last = -1;
    for (int i = 0; i < s.len(); i++) begin
      if (i == gap_at) begin
        v[ch] = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          chk("gap_ready_held", 32'(bus.req_ready[ch]), 1);
        end
        @(posedge clk); #1;
      end
      d[ch] = s[i];
      l[ch] = use_last && (i == s.len() - 1);
      v[ch] = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.req_ready[ch] && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!bus.req_ready[ch]) begin
        chk("accept_timeout", 32'(bus.req_ready[ch]), 1);
        v[ch] = 1'b0; l[ch] = 1'b0;
        return;
      end
      n_acc++;
      if (c_first < 0) c_first = cyc;
      c_last = cyc;
      @(posedge clk); #1;
    end
    v[ch] = 1'b0;
    l[ch] = 1'b0;
  endtask

  task automatic get_res(output res_t r);
    int n;
    n = 0;
    while (rd_idx >= rq.size() && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("result_present", 32'(rq.size() > rd_idx), 1);
    if (rq.size() > rd_idx) begin
      r = rq[rd_idx];
      rd_idx++;
    end else begin
      r = '{-1, -1, -1, -1};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    int na, cf, cl;
    int na0, cf0, cl0, na1, cf1, cl1, na2, cf2, cl2, na3, cf3, cl3, na4, cf4, cl4;
    int nres;
    int exp_chan [5];

    for (int i = 0; i < NCH; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; d[i] = 8'h00;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(bus.req_ready), 0);
    chk("rst_valid",  32'(bus.res_valid), 0);
    chk("rst_chan",   32'(bus.res_chan), 0);
    chk("rst_cnt",    32'(bus.res_cnt), 0);
    chk("rst_danger", 32'(bus.res_danger), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // All four channels valid together; channel 0 comes back immediately
    fork
      begin
        send(0, "AAA", -1, 0, 1, na0, cf0, cl0);
        send(0, "ATA", -1, 0, 1, na4, cf4, cl4);
      end
      send(1, "CCC", -1, 0, 1, na1, cf1, cl1);
      send(2, "GGG", -1, 0, 1, na2, cf2, cl2);
      send(3, "TTT", -1, 0, 1, na3, cf3, cl3);
    join
    exp_chan = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      get_res(r);
      chk("rr_order_chan", 32'(r.chan), 32'(exp_chan[k]));
      chk("rr_order_cnt",  32'(r.cnt), 0);
    end
    chk("rr_ch0_second_after_ch3", 32'(cf4 > cl3), 1);

    // Single pattern on channel 0
    send(0, "ATATGCGA", -1, 0, 1, na, cf, cl);
    get_res(r);
    chk("t1_chan",    32'(r.chan), 0);
    chk("t1_cnt",     32'(r.cnt), 1);
    chk("t1_danger",  32'(r.dng), 0);
    chk("t1_latency", 32'(r.cyc - cl), 1);
    chk("t1_nacc",    32'(na), 8);
    @(negedge clk);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // Overlap-dependent count on channel 2
    send(2, "ATATGCGATATGCGA", -1, 0, 1, na, cf, cl);
    get_res(r);
    chk("t2_chan", 32'(r.chan), 2);
    chk("t2_cnt",  32'(r.cnt), 32'(OVL_CNT));

    // Saturation on channel 1; every byte still accepted back to back
    send(1, "ATATGCGAATATGCGAATATGCGAATATGCGAXX", -1, 0, 1, na, cf, cl);
    get_res(r);
    chk("t4_chan",    32'(r.chan), 1);
    chk("t4_cnt",     32'(r.cnt), 3);
    chk("t4_danger",  32'(r.dng), 1);
    chk("t4_nacc",    32'(na), 34);
    chk("t4_nostall", 32'(cl - cf), 33);

    // S4 + 'A' falls back to S3, with a 2-cycle valid gap mid-stream
    send(3, "ATATATGCGA", 4, 2, 1, na, cf, cl);
    get_res(r);
    chk("t5_chan",  32'(r.chan), 3);
    chk("t5_cnt",   32'(r.cnt), 1);
    chk("t5_nacc",  32'(na), 10);
    chk("t5_span",  32'(cl - cf), 11);

    // Reset mid-sequence after 4 bytes
    send(1, "ATAT", -1, 0, 0, na, cf, cl);
    @(negedge clk);
    chk("t6_busy_pre", 32'(bus.busy), 1);
    nres = rq.size();
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_ready",  32'(bus.req_ready), 0);
    chk("t6_rst_valid",  32'(bus.res_valid), 0);
    chk("t6_rst_chan",   32'(bus.res_chan), 0);
    chk("t6_rst_cnt",    32'(bus.res_cnt), 0);
    chk("t6_rst_danger", 32'(bus.res_danger), 0);
    chk("t6_rst_busy",   32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_result", 32'(rq.size()), 32'(nres));
    send(1, "GCGAATATGCGA", -1, 0, 1, na, cf, cl);
    get_res(r);
    chk("t6_chan", 32'(r.chan), 1);
    chk("t6_cnt",  32'(r.cnt), 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dna_scan_sched.md
# dna_scan_sched

Round-robin scheduler that shares one DNA pattern matcher between several character-stream requesters. Each requester submits a sequence of ASCII bases over a valid/ready handshake, and marks the final beat with `last`. The scheduler grants one whole sequence at a time and steers its bytes into the matcher, which counts occurrences of "ATATGCGA". It reports one result per sequence: the count, which saturates, and a danger flag. The block sits between the base-stream sources and the downstream alarm/statistics logic.

## Interface
- `NCH`, default 4: number of requesters, 2..8.
- `CNT_MAX`, default 3: count saturation value; reaching it raises danger.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  NCH: per-channel beat valid.
- `req_data`  in  8*NCH: per-channel ASCII byte; channel i occupies [8i+7:8i].
- `req_last`  in  NCH: per-channel end-of-sequence marker.
- `req_ready`  out  NCH: one-hot; set only for the granted channel in STREAM.
- `res_valid`  out  1: one-cycle result pulse, with no backpressure.
- `res_chan`  out  $clog2(NCH): channel that the result belongs to.
- `res_cnt`  out  $clog2(CNT_MAX+1): match count for the sequence.
- `res_danger`  out  1: res_cnt == CNT_MAX.
- `busy`  out  1: FSM not in IDLE.

## Operation
- FSM states: IDLE, STREAM, REPORT.
- **IDLE**
  - If any `req_valid` is set, grant the first valid channel found by searching upward from `rr_ptr` with wrap.
  - Clear the matcher (state S0, count 0) and go to STREAM.
- **STREAM**
  - `req_ready[grant]` = 1.
  - A beat is accepted when valid and ready are both high. Each accepted byte steps the matcher.
  - Deasserting `req_valid` mid-sequence stalls the block; the grant is held.
  - Accepting a beat with `req_last` set moves the FSM to REPORT.
- **REPORT**
  - `res_valid` = 1, with `res_chan`/`res_cnt`/`res_danger` registered.
  - `rr_ptr` = (grant+1) mod NCH.
  - Go to IDLE.
- **Matcher states:** S0..S7 represent the matched prefix length of "ATATGCGA".
  - On the expected character, advance one state.
  - Reaching length 8 is a match: count += 1, then continue per the configuration below.
- **Mismatch rule:** if in S4 with input 'A', go to S3; otherwise any 'A' goes to S1; anything else goes to S0.
- Non-ACGT bytes are mismatches.
- **Saturation:** once count == CNT_MAX, the matcher freezes. The remaining bytes of the sequence are still accepted and discarded until `last`.
- A match completed on the `last` beat is counted in that sequence's result.
- Output reset values: `req_ready` = 0, `res_valid` = 0, `res_chan` = 0, `res_cnt` = 0, `res_danger` = 0, `busy` = 0. Internally, `rr_ptr` = 0 and the FSM is in IDLE.
- A reset mid-sequence abandons the sequence and produces no result.

## Timing
- Grant latency: `req_valid` seen in IDLE at cycle t; `req_ready` is high from t+1.
- Throughput: 1 byte per cycle in STREAM.
- The `last` beat is accepted at cycle t. `res_valid` is high at t+1 and the FSM is in IDLE at t+2. The earliest next `req_ready` is at t+3.
- Matcher and count update on the accepting edge. Result fields are stable only while `res_valid` is high.
- `req_ready` is driven from registered grant/state only, with no combinational path from `req_valid`.

## Configuration
- Macro: `DNA_SCAN_OVERLAP_EN`.
- **Defined:** after a match the matcher goes to S1, so the final 'A' is reused. "ATATGCGATATGCGA" counts 2.
- **Undefined:** after a match the matcher goes to S0. The same input counts 1.

## Structure
- Shared package `dna_pkg` holds:
  - the FSM state enum (IDLE/STREAM/REPORT)
  - the pattern constant "ATATGCGA" and its length 8
  - the ASCII codes for A/C/G/T
- Sub-module `dna_matcher` contains the pattern state, count, saturation and the overlap macro. Its interface is clk, reset, clr, step, ch, cnt, sat. `dna_scan_sched` holds the arbiter and FSM.

## Test plan
- Channel 0 sends "ATATGCGA" with last on the final 'A' → one `res_valid` pulse with `res_chan` = 0, `res_cnt` = 1, `res_danger` = 0, 1 cycle after last.
- Channel 2 sends "ATATGCGATATGCGA" → `res_cnt` = 2 with `DNA_SCAN_OVERLAP_EN`, 1 without.
- All 4 channels are valid at once, each with a 3-byte sequence → grants in order 0,1,2,3. Channel 0 sends again immediately → next grant is 0, and only after channel 3.
- Channel 1 sends the pattern 4 times and then "XX" with last → `res_cnt` = 3, `res_danger` = 1. All bytes are accepted with `req_ready` held high.
- Channel 3 sends "ATATATGCGA" with a 2-cycle `req_valid` gap inserted mid-stream → `res_cnt` = 1 (S4 on 'A' goes to S3), and no bytes are dropped.
- `reset` is pulled low during STREAM after 4 bytes → every output goes to 0 immediately. After release, the same channel's new sequence gives a fresh result with no leftover count.
